// File: rtl/mem_arbiter_ctrl_if.sv
// Client handshakes (load/store buffer, fetcher), global control and the byte-wide RAM/IO bus
// of the memory arbiter. The controller connects through the slave modport (it serves client
// requests); the environment (clients plus RAM) connects through the master modport.
interface mem_arbiter_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Global control
    logic              rdy;
    logic              rollback;
    logic              io_buffer_full;

    // RAM/IO byte bus
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    // Load/store buffer client
    logic              mc_en;
    logic              mc_wr;
    logic [ADDR_W-1:0] mc_addr;
    logic [2:0]        mc_len;
    logic [DATA_W-1:0] mc_w_data;
    logic              mc_done;
    logic [DATA_W-1:0] mc_r_data;

    // Instruction fetch client
    logic              if_en;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_data;

    modport slave (
        input  rdy, rollback, io_buffer_full, mem_din,
        input  mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
        input  if_en, if_addr,
        output mem_dout, mem_a, mem_wr,
        output mc_done, mc_r_data,
        output if_done, if_data
    );

    modport master (
        output rdy, rollback, io_buffer_full, mem_din,
        output mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
        output if_en, if_addr,
        input  mem_dout, mem_a, mem_wr,
        input  mc_done, mc_r_data,
        input  if_done, if_data
    );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Byte-serial memory controller: arbitrates the load/store buffer against the instruction
// fetcher, splits 1/2/4-byte accesses into byte beats on the 8-bit RAM/IO bus and assembles
// little-endian read data. IO stores stall while the IO buffer is full; reads abort on rollback.
module mem_arbiter_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    mem_arbiter_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LS_READ  = 3'd1;
    localparam logic [2:0] LS_WRITE = 3'd2;
    localparam logic [2:0] IF_READ  = 3'd3;
    localparam logic [2:0] COOL     = 3'd4;

    // Only 1 and 2 are honoured; every other encoding means a full word.
    function automatic logic [2:0] len_decode(input logic [2:0] len);
        case (len)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              io_q, io_d;
    // Reads: edges elapsed since acceptance. Writes: index of the next beat to issue.
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rbuf_q, rbuf_d;

    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mc_done_q, mc_done_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] mc_r_data_q, mc_r_data_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;

    logic              mc_io;
    logic [ADDR_W-1:0] beat_addr;
    logic [7:0]        wbyte;
    logic [1:0]        cap_idx;
    logic [31:0]       rd_merge;

    assign mc_io     = (bus.mc_addr[17:16] == 2'b11);
    assign beat_addr = addr_q + ADDR_W'(cnt_q);
    assign wbyte     = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    // Byte captured at edge k belongs to the beat issued at edge k-2.
    assign cap_idx   = cnt_q[1:0] - 2'd2;

    // Read buffer with the byte currently on mem_din merged into its slot.
    always_comb begin
        rd_merge = rbuf_q;
        rd_merge[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    end

    // Next-state logic for the arbiter FSM, beat sequencing and bus outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        io_d        = io_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        mc_done_d   = 1'b0;
        if_done_d   = 1'b0;
        mc_r_data_d = mc_r_data_q;
        if_data_d   = if_data_q;

        case (state_q)
            IDLE: begin
                mem_wr_d = 1'b0;
                rbuf_d   = '0;
                if (bus.mc_en && bus.mc_wr) begin
                    // Stores are accepted even during rollback: they are already committed.
                    state_d    = LS_WRITE;
                    addr_d     = bus.mc_addr;
                    len_d      = len_decode(bus.mc_len);
                    wdata_d    = bus.mc_w_data[31:0];
                    io_d       = mc_io;
                    mem_a_d    = bus.mc_addr;
                    mem_dout_d = bus.mc_w_data[7:0];
                    if (mc_io && bus.io_buffer_full) begin
                        cnt_d = 3'd0;
                    end else begin
                        mem_wr_d = 1'b1;
                        cnt_d    = 3'd1;
                    end
                end else if (bus.mc_en) begin
                    // A pending load blocks the fetcher even while rollback holds it off.
                    if (!bus.rollback) begin
                        state_d = LS_READ;
                        addr_d  = bus.mc_addr;
                        len_d   = len_decode(bus.mc_len);
                        mem_a_d = bus.mc_addr;
                        cnt_d   = 3'd1;
                    end
                end else if (bus.if_en && !bus.rollback) begin
                    state_d = IF_READ;
                    addr_d  = bus.if_addr;
                    len_d   = 3'd4;
                    mem_a_d = bus.if_addr;
                    cnt_d   = 3'd1;
                end
            end

            LS_READ, IF_READ: begin
                if (bus.rollback) begin
                    state_d  = IDLE;
                    mem_wr_d = 1'b0;
                    cnt_d    = 3'd0;
                end else begin
                    if (cnt_q < len_q) begin
                        mem_a_d = beat_addr;
                    end
                    if (cnt_q >= 3'd2) begin
                        rbuf_d = rd_merge;
                    end
                    if (cnt_q == len_q + 3'd1) begin
                        state_d = COOL;
                        cnt_d   = 3'd0;
                        if (state_q == LS_READ) begin
                            mc_done_d   = 1'b1;
                            mc_r_data_d = DATA_W'(rd_merge);
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = DATA_W'(rd_merge);
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            LS_WRITE: begin
                if (cnt_q == len_q) begin
                    state_d   = COOL;
                    mem_wr_d  = 1'b0;
                    mc_done_d = 1'b1;
                    cnt_d     = 3'd0;
                end else begin
                    mem_a_d    = beat_addr;
                    mem_dout_d = wbyte;
                    if (io_q && bus.io_buffer_full) begin
                        // Hold the beat and retry on the next edge.
                        mem_wr_d = 1'b0;
                    end else begin
                        mem_wr_d = 1'b1;
                        cnt_d    = cnt_q + 3'd1;
                    end
                end
            end

            COOL: begin
                // Gives the client one cycle to drop its enable after seeing done.
                state_d  = IDLE;
                mem_wr_d = 1'b0;
            end

            default: begin
                state_d  = IDLE;
                mem_wr_d = 1'b0;
                cnt_d    = 3'd0;
            end
        endcase
    end

    // State registers; everything freezes while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= 3'd0;
            wdata_q     <= '0;
            io_q        <= 1'b0;
            cnt_q       <= 3'd0;
            rbuf_q      <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'h00;
            mem_wr_q    <= 1'b0;
            mc_done_q   <= 1'b0;
            if_done_q   <= 1'b0;
            mc_r_data_q <= '0;
            if_data_q   <= '0;
        end else if (bus.rdy) begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            io_q        <= io_d;
            cnt_q       <= cnt_d;
            rbuf_q      <= rbuf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            mc_done_q   <= mc_done_d;
            if_done_q   <= if_done_d;
            mc_r_data_q <= mc_r_data_d;
            if_data_q   <= if_data_d;
        end
    end

    assign bus.mem_a     = mem_a_q;
    assign bus.mem_dout  = mem_dout_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mc_done   = mc_done_q;
    assign bus.mc_r_data = mc_r_data_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_data   = if_data_q;

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Byte-serial memory controller sitting directly downstream of the load/store buffer (mc_* handshake) and of the instruction fetcher (if_* handshake); drives the single-port 8-bit RAM/IO bus.
- Arbitrates the two clients, splits 1/2/4-byte accesses into byte beats, and assembles little-endian read data.
- Stalls IO writes while the IO buffer is full; aborts speculative reads on rollback.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, client data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state and outputs hold.
- rollback  in  1  pipeline flush.
- io_buffer_full  in  1  IO sink cannot accept a byte.
- mem_din  in  8  RAM read byte; valid the cycle after the RAM samples mem_a.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_W  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- mc_en  in  1  LSB request, held until done.
- mc_wr  in  1  LSB request is a store.
- mc_addr  in  ADDR_W  LSB byte address.
- mc_len  in  3  byte count: 1, 2 or 4.
- mc_w_data  in  DATA_W  store data, low bytes used.
- mc_done  out  1  one-cycle completion pulse to LSB.
- mc_r_data  out  DATA_W  load data, zero-extended past len.
- if_en  in  1  fetch request, held until done.
- if_addr  in  ADDR_W  fetch address; always 4 bytes.
- if_done  out  1  one-cycle completion pulse to fetcher.
- if_data  out  DATA_W  fetched word.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; mem_a=0, mem_dout=0, mem_wr=0.
  - mc_done=0, if_done=0, mc_r_data=0, if_data=0.
  - Beat counter=0.
- States: IDLE, LS_READ, LS_WRITE, IF_READ, COOL.
- IDLE arbitration, evaluated on each edge with rdy=1:
  - mc_en has priority over if_en.
  - mc_en and mc_wr → LS_WRITE; mc_en and !mc_wr → LS_READ; else if_en and !rollback → IF_READ.
  - A read is not accepted while rollback=1.
  - The accepting edge is E0. Address, length and data are latched at E0; the client may change them afterwards.
- Read of n bytes:
  - At edge Ei (i<n): mem_a=addr+i, mem_wr=0.
  - Byte i is captured from mem_din at edge E(i+2) into bits [8i+7:8i].
  - At E(n+1): done pulse set and read data valid; go to COOL.
  - Read latency is therefore n+1 edges after acceptance (4-byte fetch: done at E5).
- Write of n bytes:
  - At edge Ei: mem_a=addr+i, mem_dout=w_data[8i+7:8i], mem_wr=1.
  - IO address (addr[17:16]==2'b11) with io_buffer_full=1 at the would-be beat edge: drive mem_wr=0, do not advance the beat, retry next edge.
  - At En: mem_wr=0, mc_done set; go to COOL.
- COOL:
  - Lasts exactly one cycle, then IDLE.
  - Exists so that a client that drops mc_en/if_en on seeing done is never re-accepted.
  - done drops back to 0 here. Done pulses are exactly one cycle.
- Read data persistence: mc_r_data/if_data hold their value until the next completion of the same client.
- Rollback:
  - In IF_READ or LS_READ: abort at that edge. mem_wr=0, no done pulse, partial data discarded, go to IDLE. A new request may be accepted on the next edge.
  - In LS_WRITE: ignored. A committed store always completes.
- Address arithmetic: addr+i wraps modulo 2^ADDR_W.
- Invalid mc_len values (0, 3, 5–7) are treated as 4.
- rdy=0: no state, output or beat changes, including mem_wr; rollback is also ignored that cycle.
- Simultaneous mc_en and if_en: LSB is served first; fetch is accepted at the first IDLE edge after COOL.
- rst asserted mid-access: immediate return to reset values. The access is lost and no done pulse is issued.

Test Plan:
- Fetch: if_en=1, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 → mem_a 0x100..0x103 on E0..E3; if_done high one cycle after E5; if_data=0x00100513.
- LB vs LW: mc_en=1, mc_wr=0, len=1, addr=0x200 holding 0xFF → mc_r_data=0x000000FF, done after E2; same address with len=4 over bytes FF,EE,DD,CC → 0xCCDDEEFF.
- SH: len=2, addr=0x304, w_data=0xAABB1234 → beats (0x304,0x34,wr=1), (0x305,0x12,wr=1); mem_wr=0 at E2; mc_done pulse; byte at 0x306 untouched.
- IO stall: SB to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 edges, then one write beat; mc_done one cycle later.
- Contention and rollback:
  - mc_en and if_en rise together → LSB served first, COOL, then fetch.
  - Assert rollback at E2 of the fetch → no if_done; mem_wr=0; IDLE on the next edge.
  - rollback during an in-progress SW → store completes with all 4 beats.
- Async reset at E1 of a write → mem_wr=0 immediately, before the next clock; no mc_done after release.
